// File: rtl/seg_scan.sv
// Time-multiplexed scan driver for a common-anode seven-segment bank; snapshots
// all digit values once per frame and inserts a blanking gap at the head of each slot.
module seg_scan #(
   parameter int NUM_DIGITS = 8,
   parameter int DWELL      = 50000,
   parameter int BLANK      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   output logic [2:0]                seg_in,
   output logic                      seg_en,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_done
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_SHOW  = 1'b1
   } phase_t;

   logic [IW-1:0]                 idx;
   logic [CW-1:0]                 cnt;
   logic [NUM_DIGITS-1:0][2:0]    snap_d;
   logic [NUM_DIGITS-1:0]         snap_en;
   phase_t                        phase;
   logic                          slot_end;
   logic                          frame_start;

   assign slot_end    = (cnt == CW'(DWELL - 1));
   assign frame_start = (idx == '0) && (cnt == '0);

   // Slot/cycle counters plus the once-per-frame snapshot taken during frame cycle 0,
   // so slot 0 already shows fresh data when its blanking gap ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         cnt     <= '0;
         snap_d  <= '0;
         snap_en <= '0;
      end else begin
         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (frame_start) begin
            snap_d  <= digits;
            snap_en <= digit_en;
         end
      end
   end

   // Outputs decode registered state only; a disabled digit keeps its anode
   // selected but drops seg_en so the decoder drives all segments off.
   always_comb begin
      phase      = (cnt < CW'(BLANK)) ? PH_BLANK : PH_SHOW;
      seg_in     = snap_d[idx];
      seg_en     = 1'b0;
      an         = '1;
      frame_done = (idx == IW'(NUM_DIGITS - 1)) && slot_end;
      if (phase == PH_SHOW) begin
         an     = ~(NUM_DIGITS'(1) << idx);
         seg_en = snap_en[idx];
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (4 digits, dwell 4, blank 1): a frame-arithmetic
// model checked every cycle, plus hand-computed literal checks at key cycles.
module tb_seg_scan;

   localparam int ND = 4;
   localparam int DW = 4;
   localparam int BL = 1;
   localparam int FRAME = ND * DW;

   logic              clk;
   logic              rst;
   logic [3*ND-1:0]   digits;
   logic [ND-1:0]     digit_en;
   logic [2:0]        seg_in;
   logic              seg_en;
   logic [ND-1:0]     an;
   logic              frame_done;

   int checks;
   int fails;

   seg_scan #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
      .clk        (clk),
      .rst        (rst),
      .digits     (digits),
      .digit_en   (digit_en),
      .seg_in     (seg_in),
      .seg_en     (seg_en),
      .an         (an),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cycles since reset release, and the snapshot taken at each frame start.
   int         t;
   bit         armed;
   logic [2:0] mD [ND];
   logic [ND-1:0] mE;

   initial begin
      armed = 1'b0;
      t = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         t = 0;
         for (int i = 0; i < ND; i++) mD[i] = 3'd0;
         mE = '0;
         armed = 1'b1;
      end else if (armed) begin
         if (t % FRAME == 0) begin
            for (int i = 0; i < ND; i++) mD[i] = digits[3*i +: 3];
            mE = digit_en;
         end
         t = t + 1;
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (armed) begin
         int fc, slot, c;
         logic [ND-1:0] eAn;
         logic [2:0]    eSeg;
         logic          eEn, eFd;
         fc   = t % FRAME;
         slot = fc / DW;
         c    = fc % DW;
         eAn  = (c < BL) ? '1 : ~(ND'(1) << slot);
         eSeg = mD[slot];
         eEn  = (c >= BL) && mE[slot];
         eFd  = (fc == FRAME - 1);
         checks++;
         if (an !== eAn || seg_in !== eSeg || seg_en !== eEn || frame_done !== eFd) begin
            fails++;
            $display("[TB] FAIL model t=%0d: an=%b seg_in=%0d seg_en=%b fd=%b, required an=%b seg_in=%0d seg_en=%b fd=%b",
                     t, an, seg_in, seg_en, frame_done, eAn, eSeg, eEn, eFd);
         end
         checks++;
         if ($countones(~an) > 1) begin
            fails++;
            $display("[TB] FAIL onehot t=%0d: an=%b, required at most one low bit", t, an);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [ND-1:0] eAn, input logic [2:0] eSeg,
                              input logic eEn, input logic eFd);
      checks++;
      if (an !== eAn || seg_in !== eSeg || seg_en !== eEn || frame_done !== eFd) begin
         fails++;
         $display("[TB] FAIL %s: an=%b seg_in=%0d seg_en=%b fd=%b, required an=%b seg_in=%0d seg_en=%b fd=%b",
                  name, an, seg_in, seg_en, frame_done, eAn, eSeg, eEn, eFd);
      end
   endtask

   // Holds reset for n cycles and returns at the falling edge of frame cycle 0.
   task automatic applyStimulus(input logic [3*ND-1:0] d, input logic [ND-1:0] en, input int n);
      digits   = d;
      digit_en = en;
      rst      = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [3:0] litAn  [16] = '{4'hf,4'he,4'he,4'he, 4'hf,4'hd,4'hd,4'hd,
                               4'hf,4'hb,4'hb,4'hb, 4'hf,4'h7,4'h7,4'h7};
   logic [2:0] litSeg [16] = '{3'd0,3'd5,3'd5,3'd5, 3'd2,3'd2,3'd2,3'd2,
                               3'd7,3'd7,3'd7,3'd7, 3'd0,3'd0,3'd0,3'd0};
   logic       litEn  [16] = '{0,1,1,1, 0,1,1,1, 0,1,1,1, 0,1,1,1};

   initial begin
      int pulses;
      checks   = 0;
      fails    = 0;
      rst      = 1'b1;
      digits   = '0;
      digit_en = '0;

      // Reset held for 3 cycles: outputs idle throughout.
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset", 4'hf, 3'd0, 1'b0, 1'b0);
      end

      // Scan order over one full frame.
      applyStimulus({3'd0, 3'd7, 3'd2, 3'd5}, 4'b1111, 2);
      for (int k = 0; k < 16; k++) begin
         checkOutput($sformatf("scan_c%0d", k), litAn[k], litSeg[k], litEn[k], (k == 15));
         @(negedge clk);
      end

      // Enable mask: slots 0 and 2 selected but blanked, 1 and 3 shown.
      applyStimulus({3'd0, 3'd7, 3'd2, 3'd5}, 4'b1010, 2);
      repeat (2) @(negedge clk);
      checkOutput("mask_slot0", 4'he, 3'd5, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("mask_slot1", 4'hd, 3'd2, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("mask_slot2", 4'hb, 3'd7, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("mask_slot3", 4'h7, 3'd0, 1'b1, 1'b0);

      // Snapshot: digit0 changed at frame cycle 2 only appears next frame.
      applyStimulus({3'd0, 3'd7, 3'd2, 3'd5}, 4'b1111, 2);
      repeat (2) @(negedge clk);
      digits = {3'd0, 3'd7, 3'd2, 3'd6};
      @(negedge clk);
      checkOutput("snap_hold", 4'he, 3'd5, 1'b1, 1'b0);
      repeat (14) @(negedge clk);
      checkOutput("snap_new", 4'he, 3'd6, 1'b1, 1'b0);

      // Three frames: frame_done exactly at 15, 31, 47.
      applyStimulus({3'd3, 3'd1, 3'd4, 3'd2}, 4'b1111, 2);
      pulses = 0;
      for (int k = 0; k < 48; k++) begin
         if (frame_done === 1'b1) pulses++;
         if (k == 15 || k == 31 || k == 47)
            checkOutput($sformatf("wrap_c%0d", k), 4'h7, 3'd3, 1'b1, 1'b1);
         if (k == 16 || k == 32)
            checkOutput($sformatf("wrap_c%0d", k), 4'hf, 3'd2, 1'b0, 1'b0);
         @(negedge clk);
      end
      checks++;
      if (pulses != 3) begin
         fails++;
         $display("[TB] FAIL wrap_pulses: got %0d pulses, required 3", pulses);
      end

      // Reset mid-SHOW at frame cycle 6 aborts the scan; snapshot reloads afterwards.
      applyStimulus({3'd0, 3'd7, 3'd2, 3'd5}, 4'b1111, 2);
      repeat (6) @(negedge clk);
      digits = {3'd1, 3'd1, 3'd1, 3'd4};
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst", 4'hf, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_reload", 4'he, 3'd4, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("midrst_slot1", 4'hd, 3'd1, 1'b1, 1'b0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan driver for a common-anode seven-segment bank. It sits directly upstream of the 3-bit segment decoder: it cycles through NUM_DIGITS digit slots and presents one 3-bit value plus enable per slot on `seg_in`/`seg_en`. It drives the active-low digit-select lines `an` in step, with a blanking gap per slot to suppress ghosting. All digit values are snapshotted once per frame so a display never tears mid-frame.

## Interface
- `NUM_DIGITS`, 8: digit slots scanned per frame; legal 2..8.
- `DWELL`, 50000: clock cycles per slot; legal ≥ 4.
- `BLANK`, 2: leading blanked cycles of each slot; legal 1 ≤ BLANK < DWELL.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `digits`  in  3*NUM_DIGITS  digit k value at bits [3k+2:3k].
- `digit_en`  in  NUM_DIGITS  bit k enables digit k.
- `seg_in`  out  3  value for the downstream decoder.
- `seg_en`  out  1  enable for the downstream decoder.
- `an`  out  NUM_DIGITS  digit select, active-low, at most one bit low.
- `frame_done`  out  1  high for exactly the last cycle of each frame.

## Operation
- State registers:
  - `idx`: slot, 0..NUM_DIGITS-1.
  - `cnt`: cycle within slot, 0..DWELL-1.
  - `snap_d`: 3*NUM_DIGITS bits.
  - `snap_en`: NUM_DIGITS bits.
- Counters:
  - `cnt` increments every cycle.
  - At `cnt==DWELL-1`, `cnt` goes to 0 and `idx` increments.
  - `idx` wraps NUM_DIGITS-1 to 0.
  - Widths: `cnt` is clog2(DWELL) bits and `idx` is clog2(NUM_DIGITS) bits, minimum 1.
- Phase (Moore): BLANK when `cnt < BLANK`, SHOW otherwise.
- Snapshot:
  - On the edge ending the cycle with `idx==0 && cnt==0`, load `snap_d` from `digits` and `snap_en` from `digit_en`.
  - Input changes at any other time take effect only at the next frame's load.
- Outputs are a pure decode of registers, with no combinational path from `digits`, `digit_en` or `rst`:
  - `seg_in` = `snap_d[idx]` in both phases.
  - BLANK: `an` = all ones, `seg_en` = 0.
  - SHOW: `an` = all ones except bit `idx` = 0; `seg_en` = `snap_en[idx]`.
  - A disabled digit keeps its anode selected with `seg_en`=0, so the downstream decoder outputs all-segments-off.
  - `frame_done` = (`idx==NUM_DIGITS-1 && cnt==DWELL-1`).
- Reset (rst sampled high at an edge; overrides all other updates):
  - `idx`=0, `cnt`=0, `snap_d`=0, `snap_en`=0.
  - Resulting outputs: `an`=all ones, `seg_en`=0, `seg_in`=0, `frame_done`=0.
  - Reset asserted mid-slot or mid-frame aborts the scan immediately; no partial slot completes.

## Timing
- Frame length: NUM_DIGITS*DWELL cycles.
- Slot k occupies frame cycles k*DWELL .. (k+1)*DWELL-1.
  - BLANK phase: first BLANK cycles of the slot.
  - SHOW phase: remaining DWELL-BLANK cycles.
- After rst deasserts, the first cycle is frame cycle 0 (idx 0, BLANK).
  - `seg_in` shows 0 until the snapshot loads at the end of that cycle.
  - Slot 0 SHOW starts at cycle BLANK with the newly loaded snapshot (BLANK ≥ 1 guarantees this).
- Latency: a `digits` change becomes visible at the first SHOW cycle of its slot in the first frame whose load edge follows the change. The worst case is about 2 frames.
- Wrap: the cycle after `frame_done` is idx 0, cnt 0, BLANK, with no idle gap.
- `an` never has more than one bit low in any cycle.
- The BLANK phase separates every anode change, including the N-1 to 0 wrap.

## Test plan
Unless stated, run with NUM_DIGITS=4, DWELL=4, BLANK=1 (frame = 16 cycles).

- **Reset:** rst high 3 cycles -> `an`=4'b1111, `seg_en`=0, `seg_in`=0, `frame_done`=0 throughout.
- **Scan order:** digits={0,7,2,5} (digit0=5, digit1=2, digit2=7, digit3=0), `digit_en`=4'b1111, release rst. Required response by cycle after release:
  - Cycle 0: `an`=1111.
  - Cycles 1-3: `an`=1110, `seg_in`=5, `seg_en`=1.
  - Cycle 4: blank.
  - Cycles 5-7: `an`=1101, `seg_in`=2.
  - Cycles 9-11: `an`=1011, `seg_in`=7.
  - Cycles 13-15: `an`=0111, `seg_in`=0.
  - Cycle 15: `frame_done`=1, and only that cycle.
- **Enable mask:** `digit_en`=4'b1010 -> slots 0 and 2 SHOW with `an` low and `seg_en`=0; slots 1 and 3 SHOW with `seg_en`=1.
- **Snapshot:** change digit0 from 5 to 6 at frame cycle 2 -> slot 0 shows 5 for the rest of this frame, and shows 6 in the next frame's cycles 1-3.
- **Wrap/period:** run 3 frames -> `frame_done` pulses at cycles 15, 31, 47; the `an` sequence repeats with period 16; `an` is never more than one bit low.
- **Reset mid-SHOW:** assert rst for 1 cycle at frame cycle 6 -> next cycle `an`=1111, `seg_en`=0, `seg_in`=0. After release, the scan restarts at slot 0 cnt 0 and the snapshot reloads.
